lut_neuron_array: RTL and testbench



---
 rtl/lut_neuron_array.sv | 105 ++++++++++
 tb/tb_lut_neuron_array.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_array.sv
// One sparse LogicNets layer: each neuron owns a runtime-loadable truth table looked up
// through a two-stage valid/ready pipeline; tables are zeroed by a sweep after reset.
module lut_neuron_array #(
    parameter int unsigned FAN_IN   = 3,
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned OUT_BITS = 2,
    parameter int unsigned NEURONS  = 64,
    localparam int unsigned ADDR_W  = FAN_IN * IN_BITS,
    localparam int unsigned DEPTH   = 1 << ADDR_W,
    localparam int unsigned NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*ADDR_W-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS*OUT_BITS-1:0]  out_data,
    input  logic                         cfg_req,
    output logic                         cfg_ack,
    input  logic                         cfg_we,
    input  logic [NW-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    output logic                         clearing
);

    typedef enum logic [1:0] {StClear, StRun, StLoad} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              clr_cnt_q;
    logic                           v1_q, v2_q;
    logic [NEURONS*ADDR_W-1:0]      addr_q;
    logic [NEURONS*OUT_BITS-1:0]    out_q;
    logic [NEURONS*OUT_BITS-1:0]    lut_rd;
    logic [OUT_BITS-1:0]            table_q [NEURONS][DEPTH];
    logic                           adv;
    logic                           accept;
    logic                           cfg_hit;

    assign adv      = !v2_q || out_ready;
    assign in_ready = (state_q == StRun) && !cfg_req && adv;
    assign accept   = in_valid && in_ready;
    assign cfg_hit  = (state_q == StLoad) && cfg_we && (32'(cfg_neuron) < NEURONS);

    assign out_valid = v2_q;
    assign out_data  = out_q;
    assign cfg_ack   = (state_q == StLoad);
    assign clearing  = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StClear: if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = StRun;
            // Enter LOAD only once both stages are empty so table writes never race a read.
            StRun:   if (cfg_req && !v1_q && !v2_q) state_d = StLoad;
            StLoad:  if (!cfg_req) state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StClear) clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            addr_q <= '0;
            out_q  <= '0;
        end else if (adv) begin
            v1_q <= accept;
            v2_q <= v1_q;
            if (accept) addr_q <= in_data;
            if (v1_q) out_q <= lut_rd;
        end
    end

    // Table storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                for (int unsigned n = 0; n < NEURONS; n++) table_q[n][clr_cnt_q] <= '0;
            end else if (cfg_hit) begin
                table_q[cfg_neuron][cfg_addr] <= cfg_data;
            end
        end
    end

    always_comb begin
        lut_rd = '0;
        for (int unsigned n = 0; n < NEURONS; n++) begin
            lut_rd[n*OUT_BITS +: OUT_BITS] = table_q[n][addr_q[n*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: tb/tb_lut_neuron_array.sv
// Directed bench for lut_neuron_array: default 64-neuron instance plus a 5-neuron instance
// where out-of-range neuron indices are representable on cfg_neuron.
module tb_lut_neuron_array;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [383:0] in_data;
    logic [127:0] out_data;
    logic         cfg_req, cfg_ack, cfg_we, clearing;
    logic [5:0]   cfg_neuron, cfg_addr;
    logic [1:0]   cfg_data;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [29:0]  s_in_data;
    logic [9:0]   s_out_data;
    logic         s_cfg_req, s_cfg_ack, s_cfg_we, s_clearing;
    logic [2:0]   s_cfg_neuron;
    logic [5:0]   s_cfg_addr;
    logic [1:0]   s_cfg_data;

    int n_checks = 0;
    int n_pass   = 0;

    lut_neuron_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .clearing(clearing)
    );

    lut_neuron_array #(.NEURONS(5)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .cfg_req(s_cfg_req), .cfg_ack(s_cfg_ack), .cfg_we(s_cfg_we),
        .cfg_neuron(s_cfg_neuron), .cfg_addr(s_cfg_addr), .cfg_data(s_cfg_data),
        .clearing(s_clearing)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Neuron 5 is loaded with max(0, 3 - (a+b+c)).
    function automatic logic [1:0] fval(input logic [5:0] a);
        int s;
        s = int'(a[1:0]) + int'(a[3:2]) + int'(a[5:4]);
        return (s >= 3) ? 2'd0 : 2'(3 - s);
    endfunction

    function automatic logic [127:0] exp5(input logic [5:0] a);
        logic [127:0] r;
        r = '0;
        r[11:10] = fval(a);
        return r;
    endfunction

    function automatic logic [5:0] vaddr(input int i);
        return 6'((i * 37 + 5) % 64);
    endfunction

    // Same address on every neuron; checks two-edge latency and the full output word.
    task automatic lookup(input logic [5:0] a, input logic [127:0] e, input string tag);
        int w;
        w = 0;
        in_data = {64{a}};
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_acc"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        tick();
        check({tag, "_lat2"}, out_valid, 1);
        check(tag, out_data, e);
        tick();
    endtask

    // mode 0: address i on neuron 0 only, all-zero tables; mode 1: replicated vaddr, neuron 5.
    task automatic stream(input int n, input bit mode, input bit bp, input string tag);
        int sent, got, cyc;
        bit acc, was_stall;
        logic [127:0] held, e;
        sent = 0; got = 0; cyc = 0; was_stall = 1'b0; held = '0;
        while (got < n && cyc < 400) begin
            in_valid = (sent < n);
            if (mode) in_data = {64{vaddr(sent)}};
            else begin
                in_data = '0;
                in_data[5:0] = 6'(sent);
            end
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (was_stall) check({tag, "_hold"}, out_data, held);
            if (out_valid && !out_ready) check({tag, "_rdy_lo"}, in_ready, 0);
            if (out_valid && out_ready) begin
                e = mode ? exp5(vaddr(got)) : '0;
                check(tag, out_data, e);
                got++;
            end
            was_stall = out_valid && !out_ready;
            held = out_data;
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, got, n);
    endtask

    task automatic enter_load(input string tag);
        int w;
        w = 0;
        cfg_req = 1'b1;
        #1;
        while (!cfg_ack && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_ack"}, cfg_ack, 1);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic s_write(input logic [2:0] n, input logic [5:0] a, input logic [1:0] d);
        s_cfg_we = 1'b1;
        s_cfg_neuron = n;
        s_cfg_addr = a;
        s_cfg_data = d;
        tick();
    endtask

    initial begin
        int cnt, ibad, got;
        rst = 1'b1;
        in_valid = 0; in_data = '0; out_ready = 1'b1;
        cfg_req = 0; cfg_we = 0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
        s_in_valid = 0; s_in_data = '0; s_out_ready = 1'b1;
        s_cfg_req = 0; s_cfg_we = 0; s_cfg_neuron = '0; s_cfg_addr = '0; s_cfg_data = '0;
        tick();
        tick();
        check("rst_clearing", clearing, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_ack", cfg_ack, 0);

        rst = 1'b0;
        cnt = 0; ibad = 0;
        while (clearing && cnt < 200) begin
            if (in_ready) ibad++;
            tick();
            cnt++;
        end
        check("clear_cycles", cnt, 64);
        check("clear_no_ready", ibad, 0);
        check("run_in_ready", in_ready, 1);

        // Out-of-range neuron indices 5..7 on the small instance must be dropped.
        s_cfg_req = 1'b1;
        tick();
        check("s_ack", s_cfg_ack, 1);
        s_write(3'd0, 6'd0, 2'd3);
        s_write(3'd5, 6'd1, 2'd3);
        s_write(3'd6, 6'd1, 2'd3);
        s_write(3'd7, 6'd1, 2'd3);
        s_write(3'd4, 6'd2, 2'd1);
        s_cfg_we = 1'b0;
        s_cfg_req = 1'b0;
        tick();
        check("s_ack_fall", s_cfg_ack, 0);
        s_in_data = {6'd2, 6'd1, 6'd1, 6'd1, 6'd0};
        s_in_valid = 1'b1;
        tick();
        s_in_data = {5{6'd1}};
        tick();
        s_in_valid = 1'b0;
        check("s_mixed", s_out_data, 10'b01_00_00_00_11);
        tick();
        check("s_oor", s_out_data, 10'b0);

        stream(64, 1'b0, 1'b0, "zero_n0");

        enter_load("load");
        for (int a = 0; a < 64; a++) begin
            cfg_we = 1'b1;
            cfg_neuron = 6'd5;
            cfg_addr = 6'(a);
            cfg_data = fval(6'(a));
            tick();
        end
        cfg_we = 1'b0;
        cfg_req = 1'b0;
        tick();
        check("load_ack_fall", cfg_ack, 0);

        lookup(6'b000000, exp5(6'b000000), "n5_000000");
        lookup(6'b010000, 128'h800, "n5_010000");
        lookup(6'b000101, 128'h400, "n5_000101");
        lookup(6'b111111, 128'h0, "n5_111111");

        stream(10, 1'b1, 1'b1, "bp");

        // Two vectors in flight when cfg_req rises.
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = {64{6'd0}};
        tick();
        in_data = {64{6'd16}};
        tick();
        in_data = {64{6'd5}};
        cfg_req = 1'b1;
        #1;
        cnt = 0; got = 0;
        while (!cfg_ack && cnt < 20) begin
            check("mid_in_ready", in_ready, 0);
            if (out_valid) begin
                check("mid_out", out_data, (got == 0) ? exp5(6'd0) : exp5(6'd16));
                got++;
            end
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check("mid_ack_lat", cnt, 3);
        check("mid_count", got, 2);
        check("mid_ov_load", out_valid, 0);
        cfg_req = 1'b0;
        tick();
        check("mid_ack_fall", cfg_ack, 0);

        // Writes outside LOAD are ignored.
        cfg_we = 1'b1;
        cfg_neuron = 6'd5; cfg_addr = 6'd0; cfg_data = 2'd0;
        tick();
        cfg_neuron = 6'd0; cfg_data = 2'd3;
        tick();
        cfg_we = 1'b0;
        lookup(6'd0, exp5(6'd0), "run_we");

        enter_load("rl");
        cfg_we = 1'b1;
        cfg_neuron = 6'd0; cfg_addr = 6'd0; cfg_data = 2'd3;
        tick();
        cfg_neuron = 6'd9; cfg_addr = 6'd16; cfg_data = 2'd2;
        tick();
        cfg_we = 1'b0;
        rst = 1'b1;
        cfg_req = 1'b0;
        tick();
        check("rl_clearing", clearing, 1);
        check("rl_ack", cfg_ack, 0);
        check("rl_out_valid", out_valid, 0);
        rst = 1'b0;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        check("rl_clear_cycles", cnt, 64);
        lookup(6'd0, 128'h0, "rl_a0");
        lookup(6'd16, 128'h0, "rl_a16");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
